// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: ALU opcodes, operand selects,
// opcode constants and the registered decode bundle.
package decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'd0,
        A_PC   = 2'd1,
        A_ZERO = 2'd2
    } opsel_a_t;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } opsel_b_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // All-zero value is the reset bundle: ALU_ADD, A_RS1, B_RS2, flags clear.
    typedef struct packed {
        alu_op_t    alu_op;
        opsel_a_t   a_sel;
        opsel_b_t   b_sel;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rd_we;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic [2:0] funct3;
        logic       illegal;
    } decode_bundle_t;

    // funct3 to ALU op for OP / OP-IMM; alt selects SUB or SRA.
    function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction for the I/S/B/U/J formats, chosen by opcode and
// sign-extended to WIDTH. Formats without an immediate yield zero.
module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [31:0]      instr,
    output logic [WIDTH-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = WIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the fetched word into a single
// output register toward execute, with valid/ready handshake and flush.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_instr,
    input  logic [WIDTH-1:0] if_pc,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output alu_op_t          ex_alu_op,
    output logic [1:0]       ex_a_sel,
    output logic [1:0]       ex_b_sel,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [WIDTH-1:0] ex_imm,
    output logic [WIDTH-1:0] ex_pc,
    output logic             ex_rd_we,
    output logic             ex_is_load,
    output logic             ex_is_store,
    output logic             ex_is_branch,
    output logic             ex_is_jump,
    output logic [2:0]       ex_funct3,
    output logic             ex_illegal
);

    decode_bundle_t   dec;
    decode_bundle_t   bundle_d, bundle_q;
    logic [WIDTH-1:0] imm_dec;
    logic [WIDTH-1:0] imm_d, imm_q;
    logic [WIDTH-1:0] pc_d, pc_q;
    logic             valid_d, valid_q;
    logic             legal;
    logic             writes;
    logic             accept;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;

    assign opc = if_instr[6:0];
    assign f3  = if_instr[14:12];
    assign f7  = if_instr[31:25];

    imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm_dec)
    );

    always_comb begin
        dec        = '0;
        dec.rs1    = if_instr[19:15];
        dec.rs2    = if_instr[24:20];
        dec.rd     = if_instr[11:7];
        dec.funct3 = f3;
        dec.alu_op = ALU_ADD;
        dec.a_sel  = A_RS1;
        dec.b_sel  = B_RS2;
        legal      = 1'b0;
        writes     = 1'b0;
        case (opc)
            OPC_OP: begin
                legal      = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                dec.alu_op = arith_op(f3, f7[5]);
                writes     = 1'b1;
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b001:  legal = (f7 == 7'h00);
                    3'b101:  legal = (f7 == 7'h00) || (f7 == 7'h20);
                    default: legal = 1'b1;
                endcase
                // bit 30 is only an opcode modifier for shifts; for ADDI it is immediate
                dec.alu_op = arith_op(f3, (f3 == 3'b101) && f7[5]);
                dec.b_sel  = B_IMM;
                writes     = 1'b1;
            end
            OPC_LUI: begin
                legal     = 1'b1;
                dec.a_sel = A_ZERO;
                dec.b_sel = B_IMM;
                writes    = 1'b1;
            end
            OPC_AUIPC: begin
                legal     = 1'b1;
                dec.a_sel = A_PC;
                dec.b_sel = B_IMM;
                writes    = 1'b1;
            end
            OPC_LOAD: begin
                legal       = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                dec.b_sel   = B_IMM;
                dec.is_load = 1'b1;
                writes      = 1'b1;
            end
            OPC_STORE: begin
                legal        = f3 inside {3'b000, 3'b001, 3'b010};
                dec.b_sel    = B_IMM;
                dec.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                legal         = !(f3 inside {3'b010, 3'b011});
                dec.is_branch = 1'b1;
                case (f3[2:1])
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: dec.alu_op = ALU_SUB;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                legal       = (opc == OPC_JAL) || (f3 == 3'b000);
                dec.a_sel   = A_PC;
                dec.b_sel   = B_FOUR;
                dec.is_jump = 1'b1;
                writes      = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        dec.rd_we   = legal && writes && (dec.rd != 5'd0);
        dec.illegal = !legal;
        if (!legal) begin
            dec.alu_op    = ALU_ADD;
            dec.is_load   = 1'b0;
            dec.is_store  = 1'b0;
            dec.is_branch = 1'b0;
            dec.is_jump   = 1'b0;
        end
    end

    assign if_ready = !valid_q || ex_ready;
    assign accept   = if_valid && if_ready && !flush;

    always_comb begin
        valid_d  = valid_q && !ex_ready;
        bundle_d = bundle_q;
        imm_d    = imm_q;
        pc_d     = pc_q;
        if (accept) begin
            valid_d  = 1'b1;
            bundle_d = dec;
            imm_d    = imm_dec;
            pc_d     = if_pc;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_alu_op    = bundle_q.alu_op;
    assign ex_a_sel     = bundle_q.a_sel;
    assign ex_b_sel     = bundle_q.b_sel;
    assign ex_rs1       = bundle_q.rs1;
    assign ex_rs2       = bundle_q.rs2;
    assign ex_rd        = bundle_q.rd;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign ex_rd_we     = bundle_q.rd_we;
    assign ex_is_load   = bundle_q.is_load;
    assign ex_is_store  = bundle_q.is_store;
    assign ex_is_branch = bundle_q.is_branch;
    assign ex_is_jump   = bundle_q.is_jump;
    assign ex_funct3    = bundle_q.funct3;
    assign ex_illegal   = bundle_q.illegal;

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decode stage that sits between fetch and the ALU execute stage. It accepts 32-bit instructions over a valid/ready handshake and translates each one into an `alu_op_t` opcode, operand-source selects, register indices, a sign-extended immediate and control flags. It holds the result in one output register that drives execute. Branches are decoded to `ALU_SUB`, `ALU_SLT` or `ALU_SLTU` so that execute can resolve them from the ALU result and the OF/SF/CF/ZF flags.

## Interface
Parameters:
- `WIDTH`, 32: datapath and PC width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  stage can accept this cycle.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  WIDTH  PC of `if_instr`.
- `flush`  in  1  discard held and incoming instruction (branch taken or trap).
- `ex_valid`  out  1  decoded bundle valid.
- `ex_ready`  in  1  execute accepts the bundle.
- `ex_alu_op`  out  alu_op_t  ALU operation.
- `ex_a_sel`  out  2  operand A source: RS1, PC, ZERO.
- `ex_b_sel`  out  2  operand B source: RS2, IMM, FOUR.
- `ex_rs1`, `ex_rs2`, `ex_rd`  out  5 each  register indices.
- `ex_imm`  out  WIDTH  sign-extended immediate.
- `ex_pc`  out  WIDTH  PC passthrough.
- `ex_rd_we`, `ex_is_load`, `ex_is_store`, `ex_is_branch`, `ex_is_jump`  out  1 each  control flags.
- `ex_funct3`  out  3  raw funct3 (branch condition / load-store size).
- `ex_illegal`  out  1  instruction not legal RV32I.

## Operation
- Decoder is purely combinational from `if_instr`. The output register captures it when `if_valid && if_ready`.
- Opcode map, giving op / A / B:
  - OP (0110011): funct3/funct7 → ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; A=RS1, B=RS2.
  - OP-IMM (0010011): same ops without SUB; A=RS1, B=IMM (I-type).
  - LUI: ADD; A=ZERO, B=IMM (U-type).
  - AUIPC: ADD; A=PC, B=IMM (U-type).
  - LOAD, STORE: ADD; A=RS1, B=IMM (I-type or S-type).
  - BRANCH: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU; A=RS1, B=RS2. `ex_imm` carries the B-type offset.
  - JAL, JALR: ADD; A=PC, B=FOUR (link value). `ex_imm` carries the J-type or I-type offset.
- Legality rules:
  - OP requires funct7 ∈ {0000000, 0100000}, and 0100000 is legal only with funct3 000 or 101.
  - SLLI requires funct7=0. SRLI/SRAI require funct7 ∈ {0000000, 0100000}.
  - BRANCH funct3 010 and 011 are illegal. LOAD funct3 ∈ {000,001,010,100,101}. STORE funct3 ∈ {000,001,010}. JALR funct3=000.
  - Any other opcode, including all-zero, is illegal.
- On an illegal instruction: `ex_illegal=1`, `ex_alu_op=ALU_ADD`, and every flag (`rd_we`, load, store, branch, jump) is 0. The bundle still passes through the handshake.
- `ex_rd_we` is 1 for OP, OP-IMM, LUI, AUIPC, LOAD, JAL, JALR. It is forced to 0 when rd=x0.

## Timing
- Latency: 1 cycle. A transfer in cycle N appears on `ex_*` in cycle N+1.
- `if_ready = !ex_valid || ex_ready`. Full throughput when execute never stalls.
- `ex_*` bundle is stable while `ex_valid && !ex_ready`. No field may change until the transfer.
- `flush` has priority over everything:
  - Next cycle `ex_valid=0`, regardless of `ex_ready` or `if_valid`.
  - The instruction presented in the flush cycle is dropped.
  - `if_ready` is not gated by `flush`.
- Reset (`rst_n=0` at an edge): `ex_valid=0`, and all `ex_*` data outputs read 0, with `ex_alu_op=ALU_ADD`, `ex_a_sel=RS1`, `ex_b_sel=RS2`. Reset applied mid-stall drops the held bundle.
- Data fields update only on an accepted transfer or on reset. They are not cleared by flush (only `ex_valid` is).

## Structure
- Shared package `type_enums.sv` gains:
  - `opsel_a_t` (RS1, PC, ZERO) and `opsel_b_t` (RS2, IMM, FOUR).
  - RV32I opcode constants (`OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`).
  - `decode_bundle_t` struct for the `ex_*` fields.
  - `alu_op_t` is reused unchanged.
- One sub-module, `imm_gen`: combinational I/S/B/U/J immediate extraction and sign-extension selected by opcode.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), `ex_ready=1` → next cycle `ex_valid=1`, ALU_ADD, A=RS1, B=IMM, rs1=0, rd=1, imm=0xFFFFFFFF, rd_we=1.
- SUB x3,x1,x2 (0x402081B3) → ALU_SUB, B=RS2. SRAI x5,x6,3 (0x40335293) → ALU_SRA, imm[4:0]=3. SLLI with funct7=0100000 → `ex_illegal=1`, rd_we=0.
- BLTU x1,x2 (funct3=110) → ALU_SLTU, is_branch=1, rd_we=0, B-type imm sign-extended. BNE → ALU_SUB. JAL x1 → ALU_ADD, A=PC, B=FOUR, is_jump=1.
- Backpressure: three back-to-back instructions with `ex_ready=0` for 4 cycles → first bundle held bit-stable, `if_ready=0`, no loss or duplication after release.
- Flush while stalled with `if_valid=1` → next cycle `ex_valid=0`, and the following instruction decodes normally.
- Instruction 0x00000000 → `ex_illegal=1`. Reset asserted mid-stall → `ex_valid=0` and outputs at reset values the next cycle.
